// File: rtl/tdm_demux_1x8.sv
// Serial-to-parallel TDM demultiplexer: rebuilds 8-bit words from a framed bit stream.
// Define TDM_DEMUX_PARITY_EN to add a ninth even-parity slot per frame.
module tdm_demux_1x8 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in,
    input  logic       in_valid,
    input  logic       frame_start,
    output logic [7:0] out,
    output logic       out_valid,
    output logic [3:0] slot,
    output logic       locked,
    output logic       sync_err,
    output logic       par_err
);

    localparam logic [0:0] HUNT    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;

`ifdef TDM_DEMUX_PARITY_EN
    localparam logic [3:0] LAST_SLOT = 4'd8;
`else
    localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

    logic [0:0] state_reg, state_next;
    logic [3:0] slot_reg, slot_next;
    logic [7:0] shift_reg, shift_next;
    logic [7:0] out_reg, out_next;
    logic       out_valid_reg, out_valid_next;
    logic       sync_err_reg, sync_err_next;
    logic [7:0] shift_wr;

    // Shift register image with the incoming bit dropped into the current slot
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_wr
            assign shift_wr[gi] = (slot_reg == 4'(gi)) ? in : shift_reg[gi];
        end
    endgenerate

`ifdef TDM_DEMUX_PARITY_EN
    logic par_err_reg, par_err_next;
`endif

    always_comb begin
        state_next     = state_reg;
        slot_next      = slot_reg;
        shift_next     = shift_reg;
        out_next       = out_reg;
        out_valid_next = 1'b0;
        sync_err_next  = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        par_err_next   = 1'b0;
`endif
        if (in_valid) begin
            if (state_reg == HUNT) begin
                if (frame_start) begin
                    shift_next = {7'd0, in};
                    slot_next  = 4'd1;
                    state_next = COLLECT;
                end
            end else if (frame_start) begin
                // Restart on any frame_start; mid-frame it also drops the partial word
                sync_err_next = (slot_reg != 4'd0);
                shift_next    = {7'd0, in};
                slot_next     = 4'd1;
            end else if (slot_reg == 4'd0) begin
                sync_err_next = 1'b1;
                state_next    = HUNT;
            end else if (slot_reg == LAST_SLOT) begin
                slot_next = 4'd0;
`ifdef TDM_DEMUX_PARITY_EN
                if ((^{shift_reg, in}) == 1'b0) begin
                    out_next       = shift_reg;
                    out_valid_next = 1'b1;
                end else begin
                    par_err_next = 1'b1;
                end
`else
                shift_next     = shift_wr;
                out_next       = shift_wr;
                out_valid_next = 1'b1;
`endif
            end else begin
                shift_next = shift_wr;
                slot_next  = slot_reg + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= HUNT;
            slot_reg      <= 4'd0;
            shift_reg     <= 8'h00;
            out_reg       <= 8'h00;
            out_valid_reg <= 1'b0;
            sync_err_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            slot_reg      <= slot_next;
            shift_reg     <= shift_next;
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            sync_err_reg  <= sync_err_next;
        end
    end

`ifdef TDM_DEMUX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_reg <= 1'b0;
        end else begin
            par_err_reg <= par_err_next;
        end
    end
    assign par_err = par_err_reg;
`else
    assign par_err = 1'b0;
`endif

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign slot      = slot_reg;
    assign locked    = (state_reg == COLLECT);
    assign sync_err  = sync_err_reg;

endmodule

// File: tb/tb_tdm_demux_1x8.sv
// Scoreboard bench for tdm_demux_1x8: frame-level reference model, per-cycle and per-word checks.
module tb_tdm_demux_1x8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] out;
    logic       out_valid;
    logic [3:0] slot;
    logic       locked;
    logic       sync_err;
    logic       par_err;

    always #5 clk = ~clk;

    tdm_demux_1x8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in          (in),
        .in_valid    (in_valid),
        .frame_start (frame_start),
        .out         (out),
        .out_valid   (out_valid),
        .slot        (slot),
        .locked      (locked),
        .sync_err    (sync_err),
        .par_err     (par_err)
    );

`ifdef TDM_DEMUX_PARITY_EN
    localparam int FLEN = 9;
    localparam bit PAR  = 1'b1;
`else
    localparam int FLEN = 8;
    localparam bit PAR  = 1'b0;
`endif

    typedef struct {
        logic [3:0] slot;
        logic       locked;
        logic       sync_err;
        logic       par_err;
        logic       out_valid;
        logic [7:0] out;
    } exp_t;

    exp_t       cyc_q[$];
    logic [7:0] word_q[$];
    int         errors = 0;
    int         checks = 0;
    int         cycle_no = 0;

    // Reference model: frame position, lock flag, collected bits, last word
    bit         m_locked = 1'b0;
    int         m_pos = 0;
    bit         m_bits[9];
    logic [7:0] m_out = 8'h00;

    function automatic void m_start(input bit b);
        for (int i = 0; i < 9; i++) m_bits[i] = 1'b0;
        m_bits[0] = b;
        m_pos     = 1;
        m_locked  = 1'b1;
    endfunction

    task automatic drive(input bit v, input bit fs, input bit b);
        exp_t e;
        int   x;
        int   w;
        @(negedge clk);
        in_valid    = v;
        frame_start = fs;
        in          = b;
        e.sync_err  = 1'b0;
        e.par_err   = 1'b0;
        e.out_valid = 1'b0;
        if (v) begin
            if (!m_locked) begin
                if (fs) m_start(b);
            end else if (fs) begin
                if (m_pos != 0) e.sync_err = 1'b1;
                m_start(b);
            end else if (m_pos == 0) begin
                e.sync_err = 1'b1;
                m_locked   = 1'b0;
            end else begin
                m_bits[m_pos] = b;
                m_pos = m_pos + 1;
                if (m_pos == FLEN) begin
                    m_pos = 0;
                    x = 0;
                    w = 0;
                    for (int i = 0; i < FLEN; i++) x = x ^ int'(m_bits[i]);
                    for (int i = 0; i < 8; i++) w = w + (int'(m_bits[i]) << i);
                    if (!PAR || x == 0) begin
                        m_out = 8'(w);
                        word_q.push_back(8'(w));
                        e.out_valid = 1'b1;
                    end else begin
                        e.par_err = 1'b1;
                    end
                end
            end
        end
        e.slot   = 4'(m_pos);
        e.locked = m_locked;
        e.out    = m_out;
        cyc_q.push_back(e);
    endtask

    task automatic do_reset();
        exp_t e;
        @(negedge clk);
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        frame_start = 1'b0;
        in          = 1'b0;
        #1;
        checks++;
        if ({out, out_valid, slot, locked, sync_err, par_err} !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: got out=%h ov=%b slot=%0d lk=%b se=%b pe=%b, want all zero",
                     out, out_valid, slot, locked, sync_err, par_err);
        end
        m_locked = 1'b0;
        m_pos    = 0;
        m_out    = 8'h00;
        e.slot = 4'd0; e.locked = 1'b0; e.sync_err = 1'b0;
        e.par_err = 1'b0; e.out_valid = 1'b0; e.out = 8'h00;
        cyc_q.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
        cyc_q.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] w, input int gap_slot, input int gap_len, input bit bad_par);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i == 0, w[i]);
            if (i == gap_slot) repeat (gap_len) drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        end
        if (PAR) drive(1'b1, 1'b0, (^w) ^ bad_par);
    endtask

    // Monitor: per-cycle expectations, plus words popped whenever out_valid is presented
    initial begin
        exp_t e;
        logic [7:0] wexp;
        forever begin
            @(posedge clk);
            #1;
            cycle_no++;
            if (cyc_q.size() > 0) begin
                e = cyc_q.pop_front();
                checks++;
                if (slot !== e.slot || locked !== e.locked || sync_err !== e.sync_err ||
                    par_err !== e.par_err || out_valid !== e.out_valid || out !== e.out) begin
                    errors++;
                    $display("FAIL cycle %0d: got slot=%0d lk=%b se=%b pe=%b ov=%b out=%h, want slot=%0d lk=%b se=%b pe=%b ov=%b out=%h",
                             cycle_no, slot, locked, sync_err, par_err, out_valid, out,
                             e.slot, e.locked, e.sync_err, e.par_err, e.out_valid, e.out);
                end
            end
            if (out_valid === 1'b1) begin
                checks++;
                if (word_q.size() == 0) begin
                    errors++;
                    $display("FAIL word cycle %0d: got out_valid with out=%h, want no word", cycle_no, out);
                end else begin
                    wexp = word_q.pop_front();
                    if (out !== wexp) begin
                        errors++;
                        $display("FAIL word cycle %0d: got out=%h, want %h", cycle_no, out, wexp);
                    end
                end
            end
        end
    end

    initial begin
        int n;
        do_reset();
        // Basic frame, then with a 3-cycle gap between slots 3 and 4
        send_frame(8'hA5, -1, 0, 1'b0);
        repeat (2) drive(1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 3, 3, 1'b0);
        // Back-to-back frames
        send_frame(8'h3C, -1, 0, 1'b0);
        send_frame(8'hFF, -1, 0, 1'b0);
        // frame_start at slot 5, then a full frame
        for (int i = 0; i < 5; i++) drive(1'b1, i == 0, 1'b1);
        send_frame(8'h81, -1, 0, 1'b0);
        // Missing frame_start after a completed frame, then stray beats in HUNT
        drive(1'b1, 1'b0, 1'b1);
        repeat (4) drive(1'b1, 1'b0, 1'($urandom_range(0, 1)));
        // Mid-frame reset after a nonzero word
        send_frame(8'h5A, -1, 0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, i == 0, 1'b1);
        do_reset();
        // Parity cases (bad parity is ignored in the 8-slot build)
        send_frame(8'h07, -1, 0, 1'b0);
        send_frame(8'h07, -1, 0, 1'b1);
        send_frame(8'hC3, 2, 1, 1'b1);
        // Randomised traffic
        for (int k = 0; k < 300; k++) begin
            n = int'($urandom_range(0, 9));
            if (n < 6) begin
                send_frame(8'($urandom), int'($urandom_range(0, 9)) - 2, int'($urandom_range(1, 3)),
                           $urandom_range(0, 3) == 0);
            end else if (n < 9) begin
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)));
            end else begin
                do_reset();
            end
        end
        repeat (3) drive(1'b0, 1'b0, 1'b0);
        for (int t = 0; t < 20 && cyc_q.size() != 0; t++) @(posedge clk);
        #3;
        checks++;
        if (cyc_q.size() != 0 || word_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d cycles and %0d words pending, want 0 and 0",
                     cyc_q.size(), word_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
